// File: rtl/rv32_test_sequencer.sv
// rv32_test_sequencer: walks NUM_TESTS RV32 compliance images. For each image it
// holds the core and memories in reset, runs the core until ECALL or the cycle
// budget runs out, then grades the run from a7/a0 and reports it.
// Optional build macro RV32_TEST_SEQ_RESULT_LOG_EN adds a per-test pass_map output.
//
// Interface timing: start and ecall are level inputs sampled on the rising clock
// edge. start is only honoured in IDLE and ecall only in RUN; there is no
// back-pressure and no queuing. test_done and all_done are single-cycle pulses,
// and test_pass/test_timeout are meaningful only while test_done is high.
module rv32_test_sequencer #(
    parameter int          NUM_TESTS    = 36,
    parameter int          MAX_CYCLES   = 840,
    parameter int          RESET_CYCLES = 1,
    parameter int          CNT_WIDTH    = 16,
    parameter int          IDX_WIDTH    = 6,
    parameter logic [31:0] PASS_A7      = 32'd93
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ecall,
    input  logic [31:0]          reg_a7,
    input  logic [31:0]          reg_a0,
    output logic                 cpu_reset,
    output logic                 cpu_en,
    output logic [IDX_WIDTH-1:0] test_idx,
    output logic                 busy,
    output logic                 test_done,
    output logic                 test_pass,
    output logic                 test_timeout,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic [IDX_WIDTH:0]   pass_count,
    output logic                 all_done,
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
    output logic [NUM_TESTS-1:0] pass_map,
`endif
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CYC_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_TESTS - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] rst_cnt;
    logic                 timeout_q;
    logic                 pass_now;

    assign fsm_state = state_q;

    // Grade is taken while the core is frozen in CHECK, so a7/a0 are stable.
    assign pass_now = !timeout_q && (reg_a7 == PASS_A7) && (reg_a0 == 32'd0);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; ecall is checked before the budget so it wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RST;
            RST:     if (rst_cnt == RST_LAST) state_d = RUN;
            RUN:     if (ecall || (cycles == CYC_LAST)) state_d = CHECK;
            CHECK:   state_d = NEXT;
            NEXT:    state_d = (test_idx == IDX_LAST) ? FIN : RST;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and per-test bookkeeping; levels follow the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_reset    <= 1'b1;
            cpu_en       <= 1'b0;
            busy         <= 1'b0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_timeout <= 1'b0;
            all_done     <= 1'b0;
            test_idx     <= '0;
            cycles       <= '0;
            pass_count   <= '0;
            rst_cnt      <= '0;
            timeout_q    <= 1'b0;
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
            pass_map     <= '0;
`endif
        end else begin
            cpu_reset    <= (state_d == IDLE) || (state_d == RST);
            cpu_en       <= (state_d == RUN);
            busy         <= (state_d != IDLE);
            test_done    <= (state_q == CHECK);
            test_pass    <= (state_q == CHECK) && pass_now;
            test_timeout <= (state_q == CHECK) && timeout_q;
            all_done     <= (state_q == NEXT) && (state_d == FIN);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        test_idx   <= '0;
                        pass_count <= '0;
                        rst_cnt    <= '0;
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
                        pass_map   <= '0;
`endif
                    end
                end
                RST: begin
                    rst_cnt <= rst_cnt + CNT_ONE;
                    if (state_d == RUN) cycles <= '0;
                end
                RUN: begin
                    // The terminating cycle is counted, so a timeout reports MAX_CYCLES.
                    cycles <= cycles + CNT_ONE;
                    if (state_d == CHECK) timeout_q <= !ecall;
                end
                CHECK: begin
                    pass_count <= pass_count + {{IDX_WIDTH{1'b0}}, pass_now};
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
                    pass_map[test_idx] <= pass_now;
`endif
                end
                NEXT: begin
                    if (state_d == RST) begin
                        test_idx <= test_idx + IDX_ONE;
                        rst_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_test_sequencer.sv
// Directed bench for rv32_test_sequencer with a three-image sweep and an 840-cycle budget.
module tb_rv32_test_sequencer;

    localparam int NT   = 3;
    localparam int MAXC = 840;
    localparam int IDXW = 2;
    localparam int CNTW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            ecall = 1'b0;
    logic [31:0]     reg_a7 = '0;
    logic [31:0]     reg_a0 = '0;
    logic            cpu_reset, cpu_en, busy, test_done, test_pass, test_timeout, all_done;
    logic [IDXW-1:0] test_idx;
    logic [CNTW-1:0] cycles;
    logic [IDXW:0]   pass_count;
    logic [2:0]      fsm_state;
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
    logic [NT-1:0]   pass_map;
`endif

    rv32_test_sequencer #(
        .NUM_TESTS(NT), .MAX_CYCLES(MAXC), .RESET_CYCLES(1),
        .CNT_WIDTH(CNTW), .IDX_WIDTH(IDXW), .PASS_A7(32'd93)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .ecall(ecall),
        .reg_a7(reg_a7), .reg_a0(reg_a0),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .test_idx(test_idx), .busy(busy),
        .test_done(test_done), .test_pass(test_pass), .test_timeout(test_timeout),
        .cycles(cycles), .pass_count(pass_count), .all_done(all_done),
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
        .pass_map(pass_map),
`endif
        .fsm_state(fsm_state)
    );

    // Clock and pulse counters.
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int done_seen = 0;
    int fin_seen = 0;

    always @(negedge clock) begin
        if (test_done) done_seen++;
        if (all_done)  fin_seen++;
    end

    typedef struct {
        int          run_len;   // RUN cycle carrying ecall; 0 means never
        logic [31:0] a7;
        logic [31:0] a0;
        logic        exp_pass;
        logic        exp_to;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];
    int   exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drives one image: waits for RUN, raises ecall on the chosen cycle, grades the report.
    task automatic run_test(input vec_t v, input int idx);
        int k;
        int w;
        reg_a7 = v.a7;
        reg_a0 = v.a0;
        w = 0;
        while (!cpu_en && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("run_entry", {31'd0, cpu_en}, 32'd1);
        check("test_idx", {30'd0, test_idx}, idx);
        check("cpu_reset_in_run", {31'd0, cpu_reset}, 32'd0);
        k = 0;
        while (cpu_en && k < MAXC + 10) begin
            k++;
            if (k == v.run_len) ecall = 1'b1;
            @(negedge clock);
            ecall = 1'b0;
        end
        check("check_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("check_done_low", {31'd0, test_done}, 32'd0);
        @(negedge clock);
        exp_pc += v.exp_pass;
        check("test_done", {31'd0, test_done}, 32'd1);
        check("test_pass", {31'd0, test_pass}, {31'd0, v.exp_pass});
        check("test_timeout", {31'd0, test_timeout}, {31'd0, v.exp_to});
        check("cycles", {16'd0, cycles}, v.exp_cyc);
        check("pass_count", {29'd0, pass_count}, exp_pc);
    endtask

    // Full sweep over vecs[base..base+2], including start latency and end-of-sweep checks.
    task automatic do_sweep(input int base);
        int d0;
        int f0;
        d0 = done_seen;
        f0 = fin_seen;
        exp_pc = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        @(negedge clock);
        check("latency_run", {31'd0, cpu_en}, 32'd1);
        for (int i = 0; i < NT; i++) begin
            if (i == 1) start = 1'b1;    // ignored while busy
            run_test(vecs[base + i], i);
            start = 1'b0;
        end
        @(negedge clock);
        check("all_done", {31'd0, all_done}, 32'd1);
        check("fin_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        check("all_done_pulse", {31'd0, all_done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("cycles_hold", {16'd0, cycles}, vecs[base + NT - 1].exp_cyc);
        check("pass_count_hold", {29'd0, pass_count}, exp_pc);
        check("done_pulses", done_seen - d0, 32'd3);
        check("fin_pulses", fin_seen - f0, 32'd1);
    endtask

    initial begin
        vecs[0] = '{100, 32'd93, 32'd0, 1'b1, 1'b0, 100};
        vecs[1] = '{0,   32'd93, 32'd0, 1'b0, 1'b1, 840};
        vecs[2] = '{840, 32'd93, 32'd0, 1'b1, 1'b0, 840};
        vecs[3] = '{5,   32'd93, 32'd5, 1'b0, 1'b0, 5};
        vecs[4] = '{7,   32'd10, 32'd0, 1'b0, 1'b0, 7};
        vecs[5] = '{1,   32'd93, 32'd0, 1'b1, 1'b0, 1};

        // Reset values.
        repeat (2) @(negedge clock);
        check("reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_test_idx", {30'd0, test_idx}, 32'd0);
        check("reset_cycles", {16'd0, cycles}, 32'd0);
        check("reset_pass_count", {29'd0, pass_count}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {29'd0, test_done, all_done, test_pass}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Sweep 1: pass, timeout, ecall on the last budget cycle.
        do_sweep(0);
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
        check("pass_map_sweep1", {29'd0, pass_map}, 32'd5);
`endif
        @(negedge clock);
        // Sweep 2: bad a0, bad a7, ecall on the first RUN cycle.
        do_sweep(3);
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
        check("pass_map_sweep2", {29'd0, pass_map}, 32'd4);
`endif
        @(negedge clock);

        // Reset asserted mid-RUN of the second image.
        exp_pc = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        run_test(vecs[5], 0);
        reg_a7 = 32'd93;
        reg_a0 = 32'd0;
        begin
            int w;
            w = 0;
            while (!cpu_en && w < 50) begin
                @(negedge clock);
                w++;
            end
        end
        check("mid_idx", {30'd0, test_idx}, 32'd1);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("abort_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("abort_test_idx", {30'd0, test_idx}, 32'd0);
        check("abort_pass_count", {29'd0, pass_count}, 32'd0);
        check("abort_cycles", {16'd0, cycles}, 32'd0);
`ifdef RV32_TEST_SEQ_RESULT_LOG_EN
        check("abort_pass_map", {29'd0, pass_map}, 32'd0);
`endif
        begin
            int d0;
            d0 = done_seen;
            repeat (2) @(negedge clock);
            reset = 1'b1;
            ecall = 1'b1;
            repeat (5) @(negedge clock);
            ecall = 1'b0;
            check("abort_no_done", done_seen - d0, 32'd0);
            check("abort_idle", {31'd0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
